// File: rtl/shift_tx_4_pkg.sv
// Shared definitions for the shift_tx_4 serial transmitter: FSM encoding,
// direction constants and the default word length.
package shift_tx_4_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam logic MSB_FIRST = 1'b1;
   localparam logic LSB_FIRST = 1'b0;

   localparam int TX_WIDTH = 4;

endpackage

// File: rtl/shift_tx_core.sv
// Parallel-load, bidirectional shift register with a registered serial output.
// Shifting zero-fills, so the shift after the last bit leaves sout at 0.
module shift_tx_core
   import shift_tx_4_pkg::*;
#(
   parameter int WIDTH = TX_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             left,
   input  logic [WIDTH-1:0] d,
   output logic             sout
);

   logic [WIDTH-1:0] shreg_r;
   logic             sout_r;

   // sout_r always mirrors the end bit of shreg_r that leaves first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_r <= {WIDTH{1'b0}};
         sout_r  <= 1'b0;
      end else if (load) begin
         shreg_r <= d;
         sout_r  <= (left == MSB_FIRST) ? d[WIDTH-1] : d[0];
      end else if (shift) begin
         if (left == MSB_FIRST) begin
            shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
            sout_r  <= shreg_r[WIDTH-2];
         end else begin
            shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
            sout_r  <= shreg_r[1];
         end
      end else begin
         shreg_r <= shreg_r;
         sout_r  <= sout_r;
      end
   end

   assign sout = sout_r;

endmodule

// File: rtl/shift_tx_4.sv
// Parallel-in serial-out transmitter with a one-word holding slot so that
// frames can run back-to-back with no idle cycle between them.
module shift_tx_4
   import shift_tx_4_pkg::*;
#(
   parameter int WIDTH = TX_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_left,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             left_out,
   output logic             frame_start,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t             state_r;
   state_t             state_nxt;
   logic [CNT_W-1:0]   bit_cnt_r;
   logic [CNT_W-1:0]   bit_cnt_nxt;
   logic               hold_full_r;
   logic               hold_full_nxt;
   logic [WIDTH-1:0]   hold_data_r;
   logic               hold_left_r;
   logic               hold_cap_s;
   logic               left_r;
   logic               left_nxt;
   logic               frame_start_r;
   logic               frame_start_nxt;
   logic               busy_r;
   logic               accept_s;
   logic               core_load_s;
   logic               core_shift_s;
   logic               core_left_s;
   logic [WIDTH-1:0]   core_d_s;

   assign accept_s = load_valid & ~hold_full_r;

   // Next-state, counter, holding-slot and shifter control
   always_comb begin
      state_nxt       = state_r;
      bit_cnt_nxt     = bit_cnt_r;
      hold_full_nxt   = hold_full_r;
      hold_cap_s      = 1'b0;
      left_nxt        = left_r;
      frame_start_nxt = 1'b0;
      core_load_s     = 1'b0;
      core_shift_s    = 1'b0;
      core_d_s        = load_data;
      core_left_s     = left_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               core_load_s     = 1'b1;
               core_left_s     = load_left;
               left_nxt        = load_left;
               frame_start_nxt = 1'b1;
               bit_cnt_nxt     = {CNT_W{1'b0}};
               state_nxt       = ST_SHIFT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (bit_cnt_r == LAST_BIT) begin
               bit_cnt_nxt = {CNT_W{1'b0}};
               if (hold_full_r) begin
                  core_load_s     = 1'b1;
                  core_d_s        = hold_data_r;
                  core_left_s     = hold_left_r;
                  left_nxt        = hold_left_r;
                  hold_full_nxt   = 1'b0;
                  frame_start_nxt = 1'b1;
               end else if (accept_s) begin
                  core_load_s     = 1'b1;
                  core_left_s     = load_left;
                  left_nxt        = load_left;
                  frame_start_nxt = 1'b1;
               end else begin
                  // shifting out the final bit zero-fills sout for idle
                  core_shift_s = 1'b1;
                  state_nxt    = ST_IDLE;
               end
            end else begin
               bit_cnt_nxt  = bit_cnt_r + CNT_W'(1);
               core_shift_s = 1'b1;
               if (accept_s) begin
                  hold_cap_s    = 1'b1;
                  hold_full_nxt = 1'b1;
               end else begin
                  hold_cap_s = 1'b0;
               end
            end
         end
         default: begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = {CNT_W{1'b0}};
         end
      endcase
   end

   // Control state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         bit_cnt_r     <= {CNT_W{1'b0}};
         hold_full_r   <= 1'b0;
         left_r        <= 1'b0;
         frame_start_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_nxt;
         bit_cnt_r     <= bit_cnt_nxt;
         hold_full_r   <= hold_full_nxt;
         left_r        <= left_nxt;
         frame_start_r <= frame_start_nxt;
         busy_r        <= (state_nxt == ST_SHIFT) | hold_full_nxt;
      end
   end

   // Holding-slot payload, written only when a word is parked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_data_r <= {WIDTH{1'b0}};
         hold_left_r <= 1'b0;
      end else if (hold_cap_s) begin
         hold_data_r <= load_data;
         hold_left_r <= load_left;
      end else begin
         hold_data_r <= hold_data_r;
         hold_left_r <= hold_left_r;
      end
   end

   shift_tx_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .load  (core_load_s),
      .shift (core_shift_s),
      .left  (core_left_s),
      .d     (core_d_s),
      .sout  (sout)
   );

   assign load_ready  = ~hold_full_r;
   assign sout_valid  = (state_r == ST_SHIFT);
   assign left_out    = left_r;
   assign frame_start = frame_start_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_shift_tx_4.sv
// Directed bench for shift_tx_4: single frames both directions, back-to-back
// via the holding slot, last-edge accept, async reset and a 200-word stream.
module tb_shift_tx_4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] load_data;
   logic       load_left;
   logic       load_valid;
   logic       load_ready;
   logic       sout;
   logic       sout_valid;
   logic       left_out;
   logic       frame_start;
   logic       busy;

   int tests  = 0;
   int failed = 0;

   shift_tx_4 dut (
      .clk         (clk),
      .rst         (rst),
      .load_data   (load_data),
      .load_left   (load_left),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .sout        (sout),
      .sout_valid  (sout_valid),
      .left_out    (left_out),
      .frame_start (frame_start),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [3:0] d, input logic l);
      load_data  = d;
      load_left  = l;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
   endtask

   // Check n consecutive bit cycles (index 7 = first bit); optionally offer a
   // second word during cycle drv_idx.
   task automatic run_bits(input string tag, input int n, input logic [7:0] bits,
                           input logic [7:0] lefts, input logic [7:0] fss,
                           input logic [7:0] rdys, input int drv_idx,
                           input logic [3:0] d2, input logic l2);
      for (int i = 0; i < n; i++) begin
         logic [7:0] b;
         b = bits;
         chk({tag, "_sout"},  {7'd0, sout},        {7'd0, b[7-i]});
         chk({tag, "_valid"}, {7'd0, sout_valid},  8'd1);
         chk({tag, "_left"},  {7'd0, left_out},    {7'd0, lefts[7-i]});
         chk({tag, "_fs"},    {7'd0, frame_start}, {7'd0, fss[7-i]});
         chk({tag, "_rdy"},   {7'd0, load_ready},  {7'd0, rdys[7-i]});
         chk({tag, "_busy"},  {7'd0, busy},        8'd1);
         if (i == drv_idx) begin
            load_data  = d2;
            load_left  = l2;
            load_valid = 1'b1;
         end else begin
            load_valid = 1'b0;
         end
         tick();
      end
      chk({tag, "_end_valid"}, {7'd0, sout_valid},  8'd0);
      chk({tag, "_end_sout"},  {7'd0, sout},        8'd0);
      chk({tag, "_end_busy"},  {7'd0, busy},        8'd0);
      chk({tag, "_end_fs"},    {7'd0, frame_start}, 8'd0);
   endtask

   logic [3:0] words [200];
   logic       dirs  [200];
   logic [3:0] exp_q [$];
   logic       dir_q [$];

   initial begin
      int k;
      int got;
      int gaps;
      int rx_cnt;
      int cyc;
      logic [3:0] q;
      logic [3:0] ew;
      logic       ed;
      logic       started;

      rst        = 1'b1;
      load_data  = 4'd0;
      load_left  = 1'b0;
      load_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {7'd0, load_ready},  8'd1);
      chk("rst_valid", {7'd0, sout_valid},  8'd0);
      chk("rst_sout",  {7'd0, sout},        8'd0);
      chk("rst_busy",  {7'd0, busy},        8'd0);
      chk("rst_left",  {7'd0, left_out},    8'd0);
      chk("rst_fs",    {7'd0, frame_start}, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // 1011 MSB first -> 1,0,1,1
      start(4'b1011, 1'b1);
      run_bits("msb", 4, 8'b1011_0000, 8'hF0, 8'h80, 8'hFF, -1, 4'd0, 1'b0);
      tick();

      // 1011 LSB first -> 1,1,0,1 ; receiver model rebuilds 1011
      start(4'b1011, 1'b0);
      q = 4'd0;
      for (int i = 0; i < 4; i++) begin
         q = {sout, q[3:1]};
         tick();
      end
      chk("lsb_rx_q", {4'd0, q}, 8'h0B);
      chk("lsb_end_valid", {7'd0, sout_valid}, 8'd0);
      tick();

      // back-to-back via holding slot: A (msb) then 5 (lsb)
      start(4'hA, 1'b1);
      run_bits("b2b", 8, 8'b1010_1010, 8'b1111_0000, 8'b1000_1000,
               8'b1000_1111, 0, 4'h5, 1'b0);
      tick();

      // accept on last-bit edge: C then 3, both msb
      start(4'hC, 1'b1);
      run_bits("last", 8, 8'b1100_0011, 8'hFF, 8'b1000_1000, 8'hFF,
               3, 4'h3, 1'b1);
      tick();

      // async reset mid-frame with the holding slot full
      start(4'hF, 1'b1);
      load_data  = 4'hF;
      load_left  = 1'b1;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      chk("pre_rst_ready", {7'd0, load_ready}, 8'd0);
      chk("pre_rst_sout",  {7'd0, sout},       8'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_sout",  {7'd0, sout},        8'd0);
      chk("arst_valid", {7'd0, sout_valid},  8'd0);
      chk("arst_left",  {7'd0, left_out},    8'd0);
      chk("arst_fs",    {7'd0, frame_start}, 8'd0);
      chk("arst_busy",  {7'd0, busy},        8'd0);
      chk("arst_ready", {7'd0, load_ready},  8'd1);
      @(negedge clk);
      rst = 1'b0;
      gaps = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (sout_valid !== 1'b0 || sout !== 1'b0) gaps++;
      end
      chk("post_rst_residual", gaps[7:0], 8'd0);

      // 200-word stream, load_valid held high
      for (int i = 0; i < 200; i++) begin
         words[i] = 4'($urandom_range(0, 15));
         dirs[i]  = 1'($urandom_range(0, 1));
      end
      k = 0; got = 0; gaps = 0; rx_cnt = 0; cyc = 0; q = 4'd0; started = 1'b0;
      ew = 4'd0; ed = 1'b0;
      while (got < 200 && cyc < 3000) begin
         logic acc;
         load_valid = (k < 200);
         load_data  = words[k < 200 ? k : 199];
         load_left  = dirs[k < 200 ? k : 199];
         acc = load_valid && load_ready;
         if (acc) begin
            exp_q.push_back(words[k]);
            dir_q.push_back(dirs[k]);
         end
         tick();
         cyc++;
         if (acc) k++;
         if (sout_valid) begin
            started = 1'b1;
            if (rx_cnt == 0) begin
               chk("strm_fs", {7'd0, frame_start}, 8'd1);
               ed = (dir_q.size() > 0) ? dir_q.pop_front() : 1'bx;
               chk("strm_dir", {7'd0, left_out}, {7'd0, ed});
            end
            q = left_out ? {q[2:0], sout} : {sout, q[3:1]};
            rx_cnt++;
            if (rx_cnt == 4) begin
               ew = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
               chk("strm_word", {4'd0, q}, {4'd0, ew});
               rx_cnt = 0;
               got++;
            end
         end else if (started && got < 200) begin
            gaps++;
         end
      end
      load_valid = 1'b0;
      chk("strm_count", got[7:0], 8'd200);
      chk("strm_gaps",  gaps[7:0], 8'd0);
      tick();
      chk("strm_end_valid", {7'd0, sout_valid}, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
